// File: rtl/mem_axi_rd_responder_pkg.sv
// Shared encodings, FSM state type and burst address helpers for the AXI read responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Byte address of beat idx in a WRAP burst; container length is (len+1)*8 bytes.
  function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                            input logic [3:0]  len,
                                            input logic [3:0]  idx);
    logic [31:0] mask;
    logic [31:0] off;
    mask = {25'd0, len, 3'b111};
    off  = base + {25'd0, idx, 3'b000};
    return (base & ~mask) | (off & mask);
  endfunction

  function automatic logic burst_err(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [3:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (size != 3'd3) || (burst == 2'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/mem_axi_rd_responder_if.sv
// AR/R channel plus backdoor write port between the cache side (master) and the memory responder (slave).
interface mem_axi_rd_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   arid_i;
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic [3:0]            arlen_i;
  logic [2:0]            arsize_i;
  logic [1:0]            arburst_i;
  logic                  arvalid_i;
  logic                  arready_o;
  logic [ID_WIDTH-1:0]   rid_o;
  logic [63:0]           rdata_o;
  logic [1:0]            rresp_o;
  logic                  rlast_o;
  logic                  rvalid_o;
  logic                  rready_i;
  logic                  wr_en_i;
  logic [ADDR_WIDTH-1:0] wr_addr_i;
  logic [31:0]           wr_data_i;

  modport master (
    output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
           wr_en_i, wr_addr_i, wr_data_i,
    input  arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport slave (
    input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
           wr_en_i, wr_addr_i, wr_data_i,
    output arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/mem_axi_rd_responder_array.sv
// 64-bit word store with asynchronous read and a 32-bit half-word write port; contents are not reset.
module mem_axi_rd_array #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [31:0]           i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [63:0]           o_rd_data
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 3);

  logic [63:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_wr_addr[2]) r_mem[i_wr_addr[ADDR_WIDTH-1:3]][63:32] <= i_wr_data;
      else              r_mem[i_wr_addr[ADDR_WIDTH-1:3]][31:0]  <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr[ADDR_WIDTH-1:3]];
endmodule

// File: rtl/mem_axi_rd_responder.sv
// AXI3-style read-only memory responder: FIXED/INCR/WRAP bursts with programmable first-beat latency.
//  state | meaning
//  IDLE  | arready high, waiting for a request
//  WAIT  | counting down the first-beat latency
//  BURST | rvalid high, presenting beats until rlast is accepted
module mem_axi_rd_responder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 4,
  parameter int ID_WIDTH   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_axi_rd_responder_if.slave s_if
);
  localparam logic [3:0] LAT_M1  = 4'(RD_LATENCY - 1);
  localparam bit         LAT_ONE = (RD_LATENCY == 1);

  state_t                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id, r_rid, w_id;
  logic [ADDR_WIDTH-1:0] r_base, w_base, w_beat_addr;
  logic [3:0]            r_len, r_beat, r_cnt, w_len, w_idx;
  logic [1:0]            r_burst, r_rresp, w_burst;
  logic                  r_err, r_rlast, w_err;
  logic [63:0]           r_rdata, w_rd_data;
  logic                  w_idle, w_ar_hs, w_r_hs, w_load;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_ar_hs = w_idle && s_if.arvalid_i;
  assign w_r_hs  = (r_state == ST_BURST) && s_if.rready_i;

  // In IDLE the beat-0 address comes straight from the request so RD_LATENCY=1 can load at the handshake.
  assign w_id    = w_idle ? s_if.arid_i : r_id;
  assign w_base  = w_idle ? {s_if.araddr_i[ADDR_WIDTH-1:3], 3'b000} : r_base;
  assign w_len   = w_idle ? s_if.arlen_i : r_len;
  assign w_burst = w_idle ? s_if.arburst_i : r_burst;
  assign w_err   = w_idle ? burst_err(s_if.arsize_i, s_if.arburst_i, s_if.arlen_i) : r_err;
  assign w_idx   = (r_state == ST_BURST) ? (r_beat + 4'd1) : 4'd0;

  always_comb begin
    w_beat_addr = w_base;
    case (w_burst)
      BURST_FIXED: w_beat_addr = w_base;
      BURST_WRAP:  w_beat_addr = ADDR_WIDTH'(wrap_addr(32'(w_base), w_len, w_idx));
      default:     w_beat_addr = ADDR_WIDTH'(32'(w_base) + {25'd0, w_idx, 3'b000});
    endcase
  end

  assign w_load = ((r_state == ST_WAIT) && (r_cnt == 4'd0)) ||
                  (LAT_ONE && w_ar_hs) ||
                  (w_r_hs && !r_rlast);

  mem_axi_rd_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk       (clk),
    .i_wr_en   (s_if.wr_en_i),
    .i_wr_addr (s_if.wr_addr_i),
    .i_wr_data (s_if.wr_data_i),
    .i_rd_addr (w_beat_addr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (s_if.arvalid_i) w_state_nxt = LAT_ONE ? ST_BURST : ST_WAIT;
      ST_WAIT:  if (r_cnt == 4'd0) w_state_nxt = ST_BURST;
      ST_BURST: if (s_if.rready_i && r_rlast) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
      r_base  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_rid   <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_rlast <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ar_hs) begin
        r_id    <= w_id;
        r_base  <= w_base;
        r_len   <= w_len;
        r_burst <= w_burst;
        r_err   <= w_err;
        r_cnt   <= LAT_M1;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_load) begin
        r_rid   <= w_id;
        r_rdata <= w_err ? 64'd0 : w_rd_data;
        r_rresp <= w_err ? RESP_SLVERR : RESP_OKAY;
        r_rlast <= (w_idx == w_len);
        r_beat  <= w_idx;
      end
    end
  end

  assign s_if.arready_o = w_idle;
  assign s_if.rvalid_o  = (r_state == ST_BURST);
  assign s_if.rid_o     = r_rid;
  assign s_if.rdata_o   = r_rdata;
  assign s_if.rresp_o   = r_rresp;
  assign s_if.rlast_o   = r_rlast;
endmodule

// File: tb/tb_mem_axi_rd_responder.sv
// Scoreboard bench for mem_axi_rd_responder: directed requests push expected beats, a monitor pops and compares.
module tb_mem_axi_rd_responder;
  import axi_pkg::*;

  localparam int AW  = 16;
  localparam int IW  = 4;
  localparam int LAT = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [63:0]   data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_axi_rd_responder_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  mem_axi_rd_responder #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (bus)
  );

  beat_t sb_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    rr_mode  = 0;   // 0: rready high, 1: toggle each cycle, 2: driven by main sequence
  int    wseq[8]  = '{5, 6, 7, 0, 1, 2, 3, 4};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    beat_t b;
    b.id = id; b.data = d; b.resp = resp; b.last = last;
    sb_q.push_back(b);
  endtask

  task automatic bd_write(input logic [AW-1:0] addr, input logic [31:0] data);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = addr; bus.wr_data_i = data;
    @(posedge clk); #1;
    bus.wr_en_i = 1'b0;
  endtask

  task automatic bd_word(input logic [AW-1:0] addr, input logic [63:0] data);
    bd_write(addr, data[31:0]);
    bd_write(addr + 16'd4, data[63:32]);
  endtask

  task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int exp_cycles);
    int n;
    n = 0;
    while (!bus.arready_o && n < 100) begin @(posedge clk); #1; n++; end
    check("ar_ready_before_req", 64'(bus.arready_o), 64'd1);
    bus.arid_i = id; bus.araddr_i = addr; bus.arlen_i = len;
    bus.arsize_i = size; bus.arburst_i = burst; bus.arvalid_i = 1'b1;
    @(posedge clk); #1;
    bus.arvalid_i = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1; n++;
      if (bus.rvalid_o) break;
    end
    check("first_beat_latency", 64'(n), 64'(LAT));
    if (exp_cycles > 0) begin
      n = 0;
      for (int k = 0; k < 100; k++) begin
        @(posedge clk); #1; n++;
        if (bus.arready_o) break;
      end
      check("burst_cycles", 64'(n), 64'(exp_cycles));
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0 && bus.arready_o) break;
      @(posedge clk); #1;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("arready_after_burst", 64'(bus.arready_o), 64'd1);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_mode == 0)      bus.rready_i = 1'b1;
      else if (rr_mode == 1) bus.rready_i = ~bus.rready_i;
    end
  end

  // Every cycle rvalid is high the presented beat must match the queue head, stalled or not.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rvalid_o) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual rid=%h rdata=%h required no beat", bus.rid_o, bus.rdata_o);
        end else begin
          e = sb_q[0];
          check("rid",   64'(bus.rid_o),   64'(e.id));
          check("rdata", bus.rdata_o,      e.data);
          check("rresp", 64'(bus.rresp_o), 64'(e.resp));
          check("rlast", 64'(bus.rlast_o), 64'(e.last));
          check("arready_low_in_burst", 64'(bus.arready_o), 64'd0);
          if (bus.rready_i) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bus.arid_i = '0; bus.araddr_i = '0; bus.arlen_i = '0; bus.arsize_i = 3'd3;
    bus.arburst_i = BURST_INCR; bus.arvalid_i = 1'b0; bus.rready_i = 1'b0;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 64'(bus.arready_o), 64'd1);
    check("rst_rvalid",  64'(bus.rvalid_o),  64'd0);
    check("rst_rlast",   64'(bus.rlast_o),   64'd0);
    check("rst_rresp",   64'(bus.rresp_o),   64'd0);
    check("rst_rid",     64'(bus.rid_o),     64'd0);
    check("rst_rdata",   bus.rdata_o,        64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-beat INCR
    bd_word(16'h1000, 64'h1111_2222_3333_4444);
    push(4'h3, 64'h1111_2222_3333_4444, RESP_OKAY, 1'b1);
    issue_ar(4'h3, 16'h1000, 4'd0, 3'd3, BURST_INCR, 1);
    wait_idle();

    // critical-word-first WRAP, rready held high
    for (int k = 0; k < 8; k++) bd_word(16'(16'h2000 + 8 * k), 64'(k));
    for (int i = 0; i < 8; i++) push(4'h5, 64'(wseq[i]), RESP_OKAY, i == 7);
    issue_ar(4'h5, 16'h2028, 4'd7, 3'd3, BURST_WRAP, 8);
    wait_idle();

    // same WRAP with rready toggling
    rr_mode = 1;
    for (int i = 0; i < 8; i++) push(4'h9, 64'(wseq[i]), RESP_OKAY, i == 7);
    issue_ar(4'h9, 16'h2028, 4'd7, 3'd3, BURST_WRAP, 0);
    wait_idle();
    rr_mode = 0;
    @(posedge clk); #1;

    // error requests: bad size, bad WRAP length, reserved burst type
    for (int i = 0; i < 4; i++) push(4'h2, 64'd0, RESP_SLVERR, i == 3);
    issue_ar(4'h2, 16'h2000, 4'd3, 3'd2, BURST_INCR, 4);
    wait_idle();
    for (int i = 0; i < 3; i++) push(4'h4, 64'd0, RESP_SLVERR, i == 2);
    issue_ar(4'h4, 16'h2000, 4'd2, 3'd3, BURST_WRAP, 3);
    wait_idle();
    for (int i = 0; i < 2; i++) push(4'h7, 64'd0, RESP_SLVERR, i == 1);
    issue_ar(4'h7, 16'h2000, 4'd1, 3'd3, 2'd3, 2);
    wait_idle();

    // backdoor write one edge before the beat-1 load is visible
    rr_mode = 2;
    @(posedge clk); #1;
    bus.rready_i = 1'b0;
    bd_word(16'h3000, 64'hAAAA_0000_0000_0001);
    bd_word(16'h3008, 64'hBBBB_0000_0000_0002);
    push(4'h1, 64'hAAAA_0000_0000_0001, RESP_OKAY, 1'b0);
    push(4'h1, 64'hBBBB_0000_CAFE_F00D, RESP_OKAY, 1'b1);
    issue_ar(4'h1, 16'h3000, 4'd1, 3'd3, BURST_INCR, 0);
    bd_write(16'h3008, 32'hCAFE_F00D);
    bus.rready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rready_i = 1'b0;
    wait_idle();

    // backdoor write on the same edge as the beat-1 load returns old data
    bd_word(16'h3010, 64'hCCCC_0000_0000_0003);
    bd_word(16'h3018, 64'hDDDD_0000_0000_0004);
    push(4'h2, 64'hCCCC_0000_0000_0003, RESP_OKAY, 1'b0);
    push(4'h2, 64'hDDDD_0000_0000_0004, RESP_OKAY, 1'b1);
    issue_ar(4'h2, 16'h3010, 4'd1, 3'd3, BURST_INCR, 0);
    bus.rready_i = 1'b1;
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 16'h3018; bus.wr_data_i = 32'h1234_5678;
    @(posedge clk); #1;
    bus.wr_en_i = 1'b0;
    @(posedge clk); #1;
    bus.rready_i = 1'b0;
    wait_idle();
    rr_mode = 0;
    push(4'h8, 64'hDDDD_0000_1234_5678, RESP_OKAY, 1'b1);
    issue_ar(4'h8, 16'h3018, 4'd0, 3'd3, BURST_INCR, 1);
    wait_idle();

    // reset pulse while beat 3 of 8 is presented
    for (int i = 0; i < 8; i++) push(4'h6, 64'(i), RESP_OKAY, i == 7);
    issue_ar(4'h6, 16'h2000, 4'd7, 3'd3, BURST_INCR, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid",  64'(bus.rvalid_o),  64'd0);
    check("rst_mid_arready", 64'(bus.arready_o), 64'd1);
    check("beats_before_reset", 64'(sb_q.size()), 64'd5);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arready_after_release", 64'(bus.arready_o), 64'd1);
    for (int i = 0; i < 4; i++) push(4'hA, 64'(i + 2), RESP_OKAY, i == 3);
    issue_ar(4'hA, 16'h2010, 4'd3, 3'd3, BURST_INCR, 4);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
